// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words from a FIFO read port and presents them as a
// valid/ready stream. It uses a 2-entry in-order skid buffer. Reads are
// issued only when the buffer is guaranteed to have room, counting the read
// that is already in flight, so the buffer never overflows.
module fifo_rd_stream #(
    parameter int data_width  = 8,
    parameter int depth_width = 5
) (
    input  logic                   rd_clk,
    input  logic                   rd_rstn,
    input  logic                   en,
    output logic                   fifo_rd,
    input  logic [depth_width:0]   fifo_rd_num,
    input  logic [data_width-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_data_vld,
    output logic                   m_valid,
    output logic [data_width-1:0]  m_data,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [31:0]            word_cnt,
    input  logic                   cnt_clr,
    output logic                   err_unexp_vld
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             occ;        // buffered words, 0..2
    logic                   inflight;   // a read was issued last cycle
    logic [data_width-1:0]  entry0;     // oldest word, drives m_data
    logic [data_width-1:0]  entry1;     // second word
    logic                   pop;
    logic                   push;
    logic [2:0]             level;      // words buffered or owed after this cycle's pop

    assign pop   = m_valid & m_ready;
    // Data that arrives without a read in flight is flagged, not stored.
    assign push  = fifo_rd_data_vld & inflight;
    // occ + inflight never exceeds 2 and pop needs occ != 0, so this cannot underflow.
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // The issue decision looks only at the fill level, never at an empty flag.
    assign fifo_rd = (state == RUN) && (fifo_rd_num != '0) && (level < 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = entry0;
    assign busy    = (state != IDLE);

    // State register, read-in-flight tracker and sticky protocol error.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            err_unexp_vld <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state    <= state_nxt;
            inflight <= fifo_rd;
            if (fifo_rd_data_vld && !inflight) begin
                err_unexp_vld <= 1'b1;
            end
        end
    end

    // Next-state logic: leave STOP only once nothing is owed and the buffer empties.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (!inflight &&
                             ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two-entry in-order buffer: entry0 is always the oldest word.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            // NOTE: the buffer is two plain flops, not a RAM, so it is reset;
            // this keeps m_data at zero after reset and drops stale words.
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= fifo_rd_data;
                    end else begin
                        entry1 <= fifo_rd_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, order kept.
                    if (occ == 2'd1) begin
                        entry0 <= fifo_rd_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= fifo_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transferred-word counter; a clear wins over a pop in the same cycle.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            word_cnt <= 32'd0;
        end else if (cnt_clr) begin
            word_cnt <= 32'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

endmodule
